// File: rtl/mem_stage.sv
// Beta pipeline memory stage: registers ALU-stage results, issues LD/LDR/ST on a
// req/ack data bus with a timeout, and stalls upstream until the access completes.
module mem_stage #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] NOP_IR    = 32'h83FFF800,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] y,
  input  logic [31:0] st_data,
  output logic        stall,
  output logic [31:0] pc_next,
  output logic [31:0] ir_next,
  output logic [31:0] y_next,
  output logic [31:0] mem_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        bus_err
);

  localparam logic [5:0] OP_LD  = 6'b011000;
  localparam logic [5:0] OP_ST  = 6'b011001;
  localparam logic [5:0] OP_LDR = 6'b011111;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_n;
  logic [7:0]  count, count_n;
  logic [31:0] pc_mem, ir_mem, y_mem, sd_mem;
  logic        is_ld, is_st, is_ldr, is_mem, is_load;
  logic        abort, ack_seen, completing;

  assign is_ld   = (ir_mem[31:26] == OP_LD);
  assign is_st   = (ir_mem[31:26] == OP_ST);
  assign is_ldr  = (ir_mem[31:26] == OP_LDR);
  assign is_mem  = is_ld | is_st | is_ldr;
  assign is_load = is_ld | is_ldr;

  // The abort cycle is the one after TIMEOUT request cycles went unanswered.
  assign abort = (state == WAIT) && (count == TIMEOUT_CNT) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_mem <= 32'd0;
      ir_mem <= NOP_IR;
      y_mem  <= 32'd0;
      sd_mem <= 32'd0;
    end else if (!stall) begin
      pc_mem <= pc;
      ir_mem <= ir;
      y_mem  <= y;
      sd_mem <= st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= 8'd0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    case (state)
      IDLE: begin
        if (is_mem && !dmem_ack) begin
          state_n = WAIT;
          count_n = 8'd1;
        end
      end
      WAIT: begin
        if (abort || dmem_ack) begin
          state_n = IDLE;
          count_n = 8'd0;
        end else begin
          count_n = count + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = 8'd0;
      end
    endcase
  end

  // An ack only counts while a request is actually on the bus.
  always_comb begin
    dmem_req   = 1'b0;
    if (!rst && is_mem)
      dmem_req = (state == IDLE) || !abort;
    ack_seen   = dmem_req && dmem_ack;
    completing = ack_seen || abort;
    stall      = is_mem && !completing && !rst;
    bus_err    = abort;
    ir_next    = (stall || rst) ? NOP_IR : ir_mem;
    mem_rd     = 32'd0;
    if (ack_seen && is_load)
      mem_rd = dmem_rdata;
    else if (abort && is_load)
      mem_rd = ERR_RDATA;
  end

  assign dmem_we    = is_st;
  assign dmem_addr  = y_mem;
  assign dmem_wdata = is_st ? sd_mem : 32'd0;
  assign pc_next    = pc_mem;
  assign y_next     = y_mem;

endmodule
